// File: rtl/score_sched_pkg.sv
// Shared types and constants for the multi-head score scheduler.
package score_sched_pkg;

   localparam int SCORES_PER_HEAD = 16;
   localparam int ENG_AW          = 7;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_DONE,
      RD_ISSUE,
      RD_WAIT,
      OUT_HOLD,
      FINISH
   } sched_state_e;

endpackage

// File: rtl/score_head_scheduler_if.sv
// Command, engine-side and score-stream signals of the head scheduler.
// slave = scheduler side, master = host/engine/sink side.
interface score_head_scheduler_if #(
   parameter int HEAD_W = 3,
   parameter int MEM_AW = 10
);
   import score_sched_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [HEAD_W:0]   cmd_num_heads;
   logic [MEM_AW-1:0] cmd_base;

   logic              eng_start;
   logic              eng_busy;
   logic              eng_done;
   logic [ENG_AW-1:0] eng_q_addr;
   logic [ENG_AW-1:0] eng_k_addr;
   logic [MEM_AW-1:0] q_mem_addr;
   logic [MEM_AW-1:0] k_mem_addr;
   logic [3:0]        score_rd_addr;
   logic              score_rd_en;
   logic [31:0]       score_rd_data;

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;
   logic [HEAD_W-1:0] out_head;
   logic [3:0]        out_idx;
   logic              out_last;

   logic              sched_busy;
   logic              sched_done;
   logic              err_timeout;

   modport master (
      output cmd_valid, cmd_num_heads, cmd_base,
      output eng_busy, eng_done, eng_q_addr, eng_k_addr, score_rd_data,
      output out_ready,
      input  cmd_ready, eng_start, q_mem_addr, k_mem_addr, score_rd_addr, score_rd_en,
      input  out_valid, out_data, out_head, out_idx, out_last,
      input  sched_busy, sched_done, err_timeout
   );

   modport slave (
      input  cmd_valid, cmd_num_heads, cmd_base,
      input  eng_busy, eng_done, eng_q_addr, eng_k_addr, score_rd_data,
      input  out_ready,
      output cmd_ready, eng_start, q_mem_addr, k_mem_addr, score_rd_addr, score_rd_en,
      output out_valid, out_data, out_head, out_idx, out_last,
      output sched_busy, sched_done, err_timeout
   );

endinterface

// File: rtl/score_addr_xlate.sv
// Maps an engine-local Q/K address into the active head's region of shared memory.
module score_addr_xlate
   import score_sched_pkg::*;
#(
   parameter int HEAD_W      = 3,
   parameter int MEM_AW      = 10,
   parameter int HEAD_STRIDE = 32
) (
   input  logic [MEM_AW-1:0] i_base,
   input  logic [HEAD_W-1:0] i_head,
   input  logic [ENG_AW-1:0] i_eng_addr,
   output logic [MEM_AW-1:0] o_mem_addr
);

   localparam logic [MEM_AW-1:0] STRIDE = MEM_AW'(HEAD_STRIDE);

   logic [MEM_AW-1:0] w_head_off;

   // All terms are MEM_AW wide so the sum wraps modulo 2^MEM_AW.
   assign w_head_off = MEM_AW'(i_head) * STRIDE;
   assign o_mem_addr = i_base + w_head_off + MEM_AW'(i_eng_addr);

endmodule

// File: rtl/score_head_scheduler.sv
// Runs the 4x4 score engine once per head and streams its 16 scores per head.
//
// state     | meaning
// IDLE      | cmd_ready high, waiting for a command
// START     | wait for engine idle, then one-cycle eng_start
// WAIT_DONE | wait for eng_done, timeout down-counter running
// RD_ISSUE  | drive score read address/enable
// RD_WAIT   | capture read data into the output register
// OUT_HOLD  | hold the beat until out_ready
// FINISH    | end of command, sched_done follows
module score_head_scheduler
   import score_sched_pkg::*;
#(
   parameter int MAX_HEADS   = 8,
   parameter int HEAD_W      = 3,
   parameter int MEM_AW      = 10,
   parameter int HEAD_STRIDE = 32,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   score_head_scheduler_if.slave bus
);

   localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [HEAD_W:0]  MAX_NUM  = (HEAD_W+1)'(MAX_HEADS);
   localparam logic [3:0]       LAST_IDX = 4'(SCORES_PER_HEAD - 1);

   sched_state_e      r_state;
   sched_state_e      w_next;

   logic [HEAD_W:0]   r_num;
   logic [MEM_AW-1:0] r_base;
   logic [HEAD_W-1:0] r_head;
   logic [3:0]        r_idx;
   logic [TMR_W-1:0]  r_tmr;
   logic [31:0]       r_out_data;
   logic              r_out_valid;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic              w_accept;
   logic              w_start;
   logic              w_hs;
   logic              w_idx_last;
   logic              w_head_last;
   logic              w_tmr_expire;
   logic              w_rd_en;
   logic [HEAD_W:0]   w_num_sat;

   assign w_num_sat    = (bus.cmd_num_heads > MAX_NUM) ? MAX_NUM : bus.cmd_num_heads;
   assign w_hs         = r_out_valid && bus.out_ready;
   assign w_idx_last   = (r_idx == LAST_IDX);
   assign w_head_last  = (({1'b0, r_head} + (HEAD_W+1)'(1)) == r_num);
   assign w_tmr_expire = (r_tmr == TMR_W'(1));
   assign w_rd_en      = (r_state == RD_ISSUE);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_start  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.cmd_valid) begin
               w_accept = 1'b1;
               w_next   = (bus.cmd_num_heads == '0) ? FINISH : START;
            end
         end
         START: begin
            // Entered only from IDLE or OUT_HOLD, so eng_start is always preceded by a low cycle.
            if (!bus.eng_busy) begin
               w_start = 1'b1;
               w_next  = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (bus.eng_done)      w_next = RD_ISSUE;
            else if (w_tmr_expire) w_next = FINISH;
         end
         RD_ISSUE: w_next = RD_WAIT;
         RD_WAIT:  w_next = OUT_HOLD;
         OUT_HOLD: begin
            if (w_hs) begin
               if (!w_idx_last)       w_next = RD_ISSUE;
               else if (!w_head_last) w_next = START;
               else                   w_next = FINISH;
            end
         end
         FINISH:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_num       <= '0;
         r_base      <= '0;
         r_head      <= '0;
         r_idx       <= '0;
         r_tmr       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= (r_state == FINISH);
         if (w_accept) begin
            r_num  <= w_num_sat;
            r_base <= bus.cmd_base;
            r_head <= '0;
            r_idx  <= '0;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
         end
         if (w_start) begin
            r_tmr <= TMR_LOAD;
         end else if (r_state == WAIT_DONE && r_tmr != '0) begin
            r_tmr <= r_tmr - TMR_W'(1);
         end
         if (r_state == WAIT_DONE) begin
            if (bus.eng_done)      r_idx <= '0;
            else if (w_tmr_expire) r_err <= 1'b1;
         end
         if (r_state == RD_WAIT) begin
            r_out_data  <= bus.score_rd_data;
            r_out_valid <= 1'b1;
         end
         if (r_state == OUT_HOLD && w_hs) begin
            r_out_valid <= 1'b0;
            if (!w_idx_last)       r_idx  <= r_idx + 4'd1;
            else if (!w_head_last) r_head <= r_head + HEAD_W'(1);
         end
         if (r_state == FINISH) r_busy <= 1'b0;
      end
   end

   score_addr_xlate #(
      .HEAD_W      (HEAD_W),
      .MEM_AW      (MEM_AW),
      .HEAD_STRIDE (HEAD_STRIDE)
   ) u_q_xlate (
      .i_base     (r_base),
      .i_head     (r_head),
      .i_eng_addr (bus.eng_q_addr),
      .o_mem_addr (bus.q_mem_addr)
   );

   score_addr_xlate #(
      .HEAD_W      (HEAD_W),
      .MEM_AW      (MEM_AW),
      .HEAD_STRIDE (HEAD_STRIDE)
   ) u_k_xlate (
      .i_base     (r_base),
      .i_head     (r_head),
      .i_eng_addr (bus.eng_k_addr),
      .o_mem_addr (bus.k_mem_addr)
   );

   assign bus.cmd_ready     = (r_state == IDLE);
   assign bus.eng_start     = w_start;
   assign bus.score_rd_en   = w_rd_en;
   assign bus.score_rd_addr = w_rd_en ? r_idx : 4'd0;
   assign bus.out_valid     = r_out_valid;
   assign bus.out_data      = r_out_data;
   assign bus.out_head      = r_head;
   assign bus.out_idx       = r_idx;
   assign bus.out_last      = r_out_valid && w_idx_last && w_head_last;
   assign bus.sched_busy    = r_busy;
   assign bus.sched_done    = r_done;
   assign bus.err_timeout   = r_err;

endmodule

// File: tb/tb_score_head_scheduler.sv
// Directed/randomized bench for score_head_scheduler with a behavioural engine and stream model.
module tb_score_head_scheduler;

   localparam int MAX_HEADS   = 8;
   localparam int HEAD_W      = 3;
   localparam int MEM_AW      = 10;
   localparam int HEAD_STRIDE = 32;
   localparam int TIMEOUT_CYC = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   score_head_scheduler_if #(.HEAD_W(HEAD_W), .MEM_AW(MEM_AW)) bus();

   score_head_scheduler #(
      .MAX_HEADS   (MAX_HEADS),
      .HEAD_W      (HEAD_W),
      .MEM_AW      (MEM_AW),
      .HEAD_STRIDE (HEAD_STRIDE),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   // engine model state
   int   m_lat = 10;
   int   m_cnt = 0;
   int   m_starts = 0;
   bit   m_hang = 1'b0;
   bit   m_stray = 1'b0;
   logic m_busy = 1'b0;
   logic f_busy = 1'b0;
   logic s_start, s_re, s_rst;
   logic [3:0] s_ra;

   assign bus.eng_busy = m_busy | f_busy;

   always @(negedge clk) begin
      s_start = bus.eng_start;
      s_re    = bus.score_rd_en;
      s_ra    = bus.score_rd_addr;
      s_rst   = rst;
   end

   always @(posedge clk) begin
      #1;
      bus.eng_done = 1'b0;
      if (s_rst) begin
         m_cnt  = 0;
         m_busy = 1'b0;
         bus.score_rd_data = '0;
      end else begin
         if (s_start) begin
            m_starts++;
            m_cnt  = m_lat;
            m_busy = !m_hang;
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && !m_hang) begin
               bus.eng_done = 1'b1;
               m_busy = 1'b0;
            end
         end else if (m_stray && !m_hang && !m_busy && $urandom_range(7) == 0) begin
            bus.eng_done = 1'b1;
         end
         if (s_re) bus.score_rd_data = 32'h3F80_0000 + 32'((m_starts - 1) << 8) + 32'(s_ra);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_flags"}, 32'({bus.out_valid, bus.out_last, bus.eng_start, bus.score_rd_en,
                                bus.sched_busy, bus.sched_done, bus.err_timeout}), 32'd0);
      chk({tag, "_data"},  bus.out_data, 32'd0);
      chk({tag, "_head"},  32'(bus.out_head), 32'd0);
      chk({tag, "_idx"},   32'(bus.out_idx), 32'd0);
      chk({tag, "_rdaddr"}, 32'(bus.score_rd_addr), 32'd0);
      chk({tag, "_qaddr"}, 32'(bus.q_mem_addr), 32'd0);
      chk({tag, "_kaddr"}, 32'(bus.k_mem_addr), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
   endtask

   // Called at posedge+#1 with the scheduler idle.
   task automatic run_cmd(input int num, input int base, input int lat, input int rmode,
                          input bit hang, input int busy_cyc, input bit stray, input bit rst_hook);
      int n_eff, nbeats, exp_starts, bi, n_starts, h, i, busy_left;
      int accept_cyc, start_cyc, err_cyc, done_cyc;
      bit accepted, prev_start, held, got_done, err_seen, in_rst;
      logic [31:0] held_data, exp_q, exp_k;
      n_eff      = (num > MAX_HEADS) ? MAX_HEADS : num;
      nbeats     = hang ? 0 : n_eff * 16;
      exp_starts = (hang && n_eff > 0) ? 1 : n_eff;
      bi = 0; n_starts = 0; accept_cyc = 0; start_cyc = 0; err_cyc = 0; done_cyc = 0;
      accepted = 0; prev_start = 0; held = 0; got_done = 0; err_seen = 0; in_rst = 0;
      held_data = '0;
      m_lat = lat; m_hang = hang; m_stray = stray; m_starts = 0;
      busy_left = busy_cyc;
      f_busy = (busy_left > 0);
      bus.cmd_valid     = 1'b1;
      bus.cmd_num_heads = (HEAD_W+1)'(num);
      bus.cmd_base      = MEM_AW'(base);
      for (int c = 0; c < 4000 && !got_done; c++) begin
         @(negedge clk);
         if (!accepted && bus.cmd_valid && bus.cmd_ready) begin
            accepted = 1; accept_cyc = cyc;
         end else if (accepted) begin
            if (bus.cmd_valid) chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
            if (cyc == accept_cyc + 1) chk("err_clear", 32'(bus.err_timeout), 32'd0);
         end
         if (bus.eng_start) begin
            chk("start_gap", 32'(prev_start), 32'd0);
            chk("start_busy", 32'(bus.eng_busy), 32'd0);
            chk("busy_flag", 32'(bus.sched_busy), 32'd1);
            if (n_starts == 0) chk("first_start", 32'(cyc - accept_cyc), 32'(busy_cyc > 1 ? busy_cyc : 1));
            n_starts++; start_cyc = cyc;
         end
         prev_start = bus.eng_start;
         if (held) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", bus.out_data, held_data);
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("extra_beat", 32'(bi < nbeats), 32'd1);
            h = bi / 16; i = bi % 16;
            chk("data", bus.out_data, 32'h3F80_0000 + 32'(h << 8) + 32'(i));
            chk("head", 32'(bus.out_head), 32'(h));
            chk("idx",  32'(bus.out_idx), 32'(i));
            chk("last", 32'(bus.out_last), 32'(h == n_eff - 1 && i == 15));
            bi++;
         end
         held = bus.out_valid && !bus.out_ready;
         held_data = bus.out_data;
         if (m_cnt == 3 && m_starts > 0) begin
            exp_q = 32'((base + (m_starts - 1) * HEAD_STRIDE + int'(bus.eng_q_addr)) % 1024);
            exp_k = 32'((base + (m_starts - 1) * HEAD_STRIDE + int'(bus.eng_k_addr)) % 1024);
            chk("q_addr", 32'(bus.q_mem_addr), exp_q);
            chk("k_addr", 32'(bus.k_mem_addr), exp_k);
         end
         if (accepted && bus.err_timeout && !err_seen && cyc > accept_cyc + 1) begin
            err_seen = 1; err_cyc = cyc;
            chk("timeout_cyc", 32'(cyc - start_cyc), 32'(TIMEOUT_CYC));
         end
         if (bus.sched_done) begin
            got_done = 1; done_cyc = cyc;
         end
         if (!got_done) begin
            @(posedge clk); #1;
            if (in_rst) begin
               chk_reset_outputs("rst_mid");
               rst = 1'b0;
               return;
            end
            if (accepted) bus.cmd_valid = 1'b0;
            if (stray && accepted && bus.out_valid && $urandom_range(3) == 0) begin
               bus.cmd_valid = 1'b1;
               bus.cmd_num_heads = (HEAD_W+1)'($urandom_range(8));
            end
            case (rmode)
               0:       bus.out_ready = 1'b1;
               1:       bus.out_ready = (cyc % 3 == 0);
               default: bus.out_ready = 1'($urandom_range(1));
            endcase
            bus.eng_q_addr = 7'($urandom);
            bus.eng_k_addr = 7'($urandom);
            if (busy_left > 0) busy_left--;
            f_busy = (busy_left > 0);
            if (rst_hook && bus.out_valid && bus.out_head == 3'd1 && bus.out_idx == 4'd7) begin
               bus.out_ready = 1'b0;
               bus.eng_q_addr = '0;
               bus.eng_k_addr = '0;
               rst = 1'b1;
               in_rst = 1;
            end
         end
      end
      chk("done_seen", 32'(got_done), 32'd1);
      if (num == 0) chk("done_lat0", 32'(done_cyc - accept_cyc), 32'd2);
      if (hang) chk("done_after_err", 32'(done_cyc - err_cyc), 32'd1);
      chk("beats", 32'(bi), 32'(nbeats));
      chk("starts", 32'(n_starts), 32'(exp_starts));
      chk("err_flag", 32'(err_seen), 32'(hang));
      @(negedge clk);
      chk("done_pulse", 32'(bus.sched_done), 32'd0);
      chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
      chk("idle_busy", 32'(bus.sched_busy), 32'd0);
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_num_heads = '0;
      bus.cmd_base = '0;
      bus.eng_done = 1'b0;
      bus.eng_q_addr = '0;
      bus.eng_k_addr = '0;
      bus.score_rd_data = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst_init");
      rst = 1'b0;
      @(posedge clk); #1;

      run_cmd(2, 'h100, 50, 0, 1'b0, 0, 1'b0, 1'b0);
      run_cmd(0, 'h055, 10, 0, 1'b0, 0, 1'b0, 1'b0);
      run_cmd(3, int'($urandom_range(1023)), int'($urandom_range(20, 4)), 1, 1'b0, 0, 1'b1, 1'b0);
      run_cmd(2, 'h3F0, 20, 0, 1'b1, 0, 1'b0, 1'b0);
      run_cmd(1, 'h200, 8, 2, 1'b0, 10, 1'b0, 1'b0);
      run_cmd(12, 'h3E0, 4, 2, 1'b0, 0, 1'b1, 1'b0);
      run_cmd(2, 'h100, 6, 0, 1'b0, 0, 1'b0, 1'b1);
      run_cmd(2, int'($urandom_range(1023)), int'($urandom_range(30, 4)), 2, 1'b0, 0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/score_head_scheduler.md
Name: score_head_scheduler

Overview:
Sequences the 4x4 score engine, score_calculation_4x128_regfile, over several attention heads. Per head it:
- translates the engine's 7-bit Q/K addresses into a per-head region of the shared Q/K memories;
- pulses the engine start and waits for done;
- drains the 16 FP32 scores through the engine read port onto a valid/ready output stream.

It sits between the host command path and the score engine.

Parameters:
MAX_HEADS, 8, maximum heads per command
HEAD_W, 3, width of head index (clog2 MAX_HEADS)
MEM_AW, 10, Q/K memory address width
HEAD_STRIDE, 32, address offset between consecutive heads' Q/K regions
TIMEOUT_CYC, 4096, max cycles to wait for engine done

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_num_heads  in  HEAD_W+1  heads to process (0..MAX_HEADS)
cmd_base  in  MEM_AW  address of head 0
eng_start  out  1  to engine Reg_WrEn
eng_busy  in  1  engine busy
eng_done  in  1  engine done pulse
eng_q_addr  in  7  engine Q_mem_addr
eng_k_addr  in  7  engine K_mem_addr
q_mem_addr  out  MEM_AW  to Q memory
k_mem_addr  out  MEM_AW  to K memory
score_rd_addr  out  4  to engine
score_rd_en  out  1  to engine
score_rd_data  in  32  from engine, valid 1 cycle after rd_en
out_valid  out  1  score stream valid
out_ready  in  1  score stream ready
out_data  out  32  FP32 score
out_head  out  HEAD_W  head index
out_idx  out  4  score index 4*i+j
out_last  out  1  last score of last head
sched_busy  out  1  command in progress
sched_done  out  1  1-cycle pulse at command end
err_timeout  out  1  sticky; cleared on next accepted command

Behaviour:
Clock and reset:
- One clock clk; reset rst is synchronous and active-high.
- Reset sets every output to 0 and state to IDLE, including mid-command. The in-flight command is dropped.
- The engine shares the system reset; the scheduler does not reset it.

Address translation (combinational):
- q_mem_addr = base_r + head*HEAD_STRIDE + eng_q_addr, modulo 2^MEM_AW.
- k_mem_addr uses the same formula with eng_k_addr.
- base_r and head are registered at command accept.

States:
- IDLE: cmd_ready=1. On cmd_valid, latch num and base, set head=0, clear err_timeout, sched_busy=1.
  - num=0: go to FINISH.
  - Otherwise: go to START.
- START: if eng_busy=0, eng_start=1 for exactly one cycle, clear the timeout counter, go to WAIT_DONE. If eng_busy=1, hold eng_start=0 and wait.
- WAIT_DONE: eng_start=0, count cycles.
  - eng_done: idx=0, go to RD_ISSUE.
  - Counter reaches TIMEOUT_CYC: set err_timeout=1, go to FINISH with no further output.
- RD_ISSUE: score_rd_en=1, score_rd_addr=idx, go to RD_WAIT.
- RD_WAIT: capture score_rd_data into out_data, set out_valid=1, go to OUT_HOLD.
- OUT_HOLD: out_data, out_head, out_idx and out_last stay stable until out_valid&&out_ready. On handshake, drop out_valid.
  - idx<15: idx+1, go to RD_ISSUE.
  - idx=15, head<num-1: head+1, go to START.
  - Otherwise: go to FINISH.
- FINISH: sched_done=1 for one cycle, sched_busy=0, go to IDLE.

Timing and stream rules:
- Minimum 3 cycles per score (no throughput pipelining required).
- out_last=1 only when idx=15 and head=num-1.
- eng_start always has at least one low cycle before it, so the engine's edge detector sees every start.
- eng_done arriving outside WAIT_DONE is ignored.
- cmd_valid while busy is ignored (cmd_ready=0).
- cmd_num_heads > MAX_HEADS is saturated to MAX_HEADS.

Decomposition:
- Package score_sched_pkg holds:
  - the state enum (IDLE, START, WAIT_DONE, RD_ISSUE, RD_WAIT, OUT_HOLD, FINISH);
  - SCORES_PER_HEAD=16;
  - ENG_AW=7.
- One sub-module is natural: score_addr_xlate, the combinational base + head*stride + engine-address adder, instantiated twice (Q and K).

Test Plan:
- cmd num=2, base=0x100, engine model done after 50 cycles, out_ready=1 → 32 beats; head0 idx0..15, then head1 idx0..15. out_last only on beat 32. One sched_done. During head1, eng_q_addr=5 → q_mem_addr=0x125.
- num=0 → sched_done 2 cycles after accept, no out_valid, no eng_start.
- out_ready toggling 1-of-3 cycles → no beat lost or duplicated; out_data stable while out_valid&&!out_ready. Scores match model values 0x3F800000+idx.
- Engine never asserts done, TIMEOUT_CYC=64 → err_timeout=1 at 64 cycles after eng_start, then sched_done. err_timeout clears on the next accepted command.
- eng_busy held high 10 cycles at command accept → eng_start delayed until eng_busy falls; exactly one start pulse per head.
- rst asserted during OUT_HOLD of head1 idx7 → next cycle all outputs 0, cmd_ready=1. A new command completes normally.
